// File: rtl/vad_pkg.sv
// Shared types and helpers for the voice activity detector: FSM states,
// widths and the saturating absolute-value function.
package vad_pkg;
  localparam int ID_W     = 6;
  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {IDLE, ONSET, ACTIVE, HANG, REPORT} vad_state_e;

  // -128 has no positive 8-bit twin, so it clamps to 127 to keep the result 7 bits
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
    if (s[SAMPLE_W-1] && (s[SAMPLE_W-2:0] == '0)) return '1;
    else if (s[SAMPLE_W-1]) return (SAMPLE_W-1)'(-s);
    else return s[SAMPLE_W-2:0];
  endfunction
endpackage

// File: rtl/voice_activity_detector_if.sv
// Sample stream in, energy/activity/utterance-ID out. The detector uses
// the slave modport; the sample source uses master.
interface voice_activity_detector_if;
  import vad_pkg::*;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic [7:0]                 frame_energy;
  logic                       active;
  logic [ID_W-1:0]            ID;
  logic                       id_valid;

  modport master (output sample_valid, sample,
                  input  frame_energy, active, ID, id_valid);
  modport slave  (input  sample_valid, sample,
                  output frame_energy, active, ID, id_valid);
endinterface

// File: rtl/frame_energy_acc.sv
// Per-frame mean-absolute energy: rectify, accumulate FRAME_LEN accepted
// samples, then latch sum/FRAME_LEN and pulse frame_done for one cycle.
module frame_energy_acc
  import vad_pkg::*;
#(
  parameter int FRAME_LEN = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [7:0]                 energy,
  output logic                       frame_done
);
  localparam int LG = $clog2(FRAME_LEN);
  localparam int AW = LG + SAMPLE_W - 1;

  logic [AW-1:0]       sum, sum_nxt;
  logic [LG-1:0]       cnt;
  logic [SAMPLE_W-2:0] mag;

  assign mag     = abs_sat(sample);
  assign sum_nxt = sum + AW'(mag);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum        <= '0;
      cnt        <= '0;
      energy     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample_valid) begin
        if (cnt == LG'(FRAME_LEN - 1)) begin
          // final sample folds straight into the latched energy
          energy     <= 8'(sum_nxt >> LG);
          sum        <= '0;
          cnt        <= '0;
          frame_done <= 1'b1;
        end else begin
          sum <= sum_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/voice_activity_detector.sv
// Frame-based VAD: onset/hangover FSM over per-frame energy; reports the
// loud-frame count of each utterance as ID. NOISE_FLOOR_ADAPT_EN enables
// an adaptive noise floor under the threshold.
module voice_activity_detector
  import vad_pkg::*;
#(
  parameter int FRAME_LEN    = 64,
  parameter int THRESH       = 16,
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 4
) (
  input logic                      clk,
  input logic                      reset,
  voice_activity_detector_if.slave bus
);
  localparam logic [3:0]      ONSET_N = 4'(ONSET_FRAMES);
  localparam logic [3:0]      HANG_N  = 4'(HANG_FRAMES);
  localparam logic [ID_W-1:0] LEN_MAX = '1;

  logic [7:0] energy, threshold;
  logic       frame_done, loud;

  frame_energy_acc #(.FRAME_LEN(FRAME_LEN)) u_acc (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .sample       (bus.sample),
    .energy       (energy),
    .frame_done   (frame_done)
  );

  vad_state_e      state, state_nxt;
  logic [3:0]      onset_cnt, onset_nxt, hang_cnt, hang_nxt;
  logic [ID_W-1:0] len, len_nxt, len_inc, id_q;
  logic            id_load, id_valid_q;

`ifdef NOISE_FLOOR_ADAPT_EN
  logic [7:0]        floor_q;
  logic [8:0]        thr_sum;
  logic signed [8:0] diff, step;

  assign thr_sum   = {1'b0, floor_q} + 9'(THRESH);
  assign threshold = thr_sum[8] ? 8'hFF : thr_sum[7:0];
  assign diff      = $signed({1'b0, energy}) - $signed({1'b0, floor_q});
  assign step      = diff >>> 3;

  // floor only tracks background: quiet frames seen while idle
  always_ff @(posedge clk) begin
    if (reset) floor_q <= '0;
    else if (frame_done && state == IDLE && !loud) floor_q <= floor_q + step[7:0];
  end
`else
  assign threshold = 8'(THRESH);
`endif

  assign loud    = energy >= threshold;
  assign len_inc = (len == LEN_MAX) ? LEN_MAX : len + 1'b1;

  always_comb begin
    state_nxt = state;
    onset_nxt = onset_cnt;
    hang_nxt  = hang_cnt;
    len_nxt   = len;
    id_load   = 1'b0;
    case (state)
      IDLE: if (frame_done && loud) begin
        onset_nxt = 4'd1;
        len_nxt   = 1;
        state_nxt = (ONSET_N == 4'd1) ? ACTIVE : ONSET;
      end
      ONSET: if (frame_done) begin
        if (loud) begin
          onset_nxt = onset_cnt + 4'd1;
          len_nxt   = len_inc;
          if (onset_cnt + 4'd1 == ONSET_N) state_nxt = ACTIVE;
        end else begin
          state_nxt = IDLE;
          len_nxt   = '0;
        end
      end
      ACTIVE: if (frame_done) begin
        if (loud) len_nxt = len_inc;
        else begin
          hang_nxt  = 4'd1;
          state_nxt = (HANG_N == 4'd1) ? REPORT : HANG;
        end
      end
      HANG: if (frame_done) begin
        if (loud) begin
          state_nxt = ACTIVE;
          len_nxt   = len_inc;
          hang_nxt  = '0;
        end else begin
          hang_nxt = hang_cnt + 4'd1;
          if (hang_cnt + 4'd1 == HANG_N) state_nxt = REPORT;
        end
      end
      REPORT: begin
        id_load   = 1'b1;
        state_nxt = IDLE;
        len_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      onset_cnt  <= '0;
      hang_cnt   <= '0;
      len        <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      onset_cnt  <= onset_nxt;
      hang_cnt   <= hang_nxt;
      len        <= len_nxt;
      id_valid_q <= id_load;
      if (id_load) id_q <= len;
    end
  end

  assign bus.frame_energy = energy;
  assign bus.active       = (state == ACTIVE) || (state == HANG);
  assign bus.ID           = id_q;
  assign bus.id_valid     = id_valid_q;
endmodule
